// File: rtl/mem_io_bridge.sv
// CPU-to-async-SRAM bridge with one memory-mapped IO word (board switches in, hex display out).
// SRAM strobes are registered from the next state, so they never glitch within a state.
module mem_io_bridge #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 20,
   parameter int WAIT_STATES = 1,
   parameter int HEX_DIGITS  = 4,
   parameter logic [ADDR_W-1:0] IO_ADDR = '1
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    req,
   input  logic                    we,
   input  logic [1:0]              be,
   input  logic [ADDR_W-1:0]       addr,
   input  logic [DATA_W-1:0]       wdata,
   output logic [DATA_W-1:0]       rdata,
   output logic                    ack,
   output logic                    busy,
   input  logic [DATA_W-1:0]       switches,
   output logic [4*HEX_DIGITS-1:0] hex,
   output logic                    CE,
   output logic                    UB,
   output logic                    LB,
   output logic                    OE,
   output logic                    WE,
   output logic [ADDR_W-1:0]       ADDR,
   inout  wire  [DATA_W-1:0]       Data
);

   // state  | meaning
   // IDLE   | strobes released, waiting for req
   // SETUP  | CE and address presented, OE/WE still high
   // ACCESS | OE (read) or WE (write) low for WAIT_STATES+1 cycles
   // DONE   | ack cycle; write data held one more cycle

   localparam int HEX_W = 4 * HEX_DIGITS;
   localparam int EXT_W = (HEX_W > DATA_W) ? HEX_W : DATA_W;
   localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   state_t              state, state_nxt;
   logic                we_q, io_q, data_oe;
   logic [1:0]          be_q, be_eff;
   logic [DATA_W-1:0]   wdata_q, sw_meta, sw_sync;
   logic [3:0]          wait_cnt;
   logic                accept, is_io, last_access;
   logic                s_we, s_io;
   logic [1:0]          s_be;
   logic                ce_n, ub_n, lb_n, oe_n, we_n, drv_n;
   logic [EXT_W-1:0]    wext;
   logic [HEX_W-1:0]    hex_mask;

   // An 8-bit bus has a single lane; UB simply mirrors LB there.
   assign be_eff      = (DATA_W == 8) ? {be[0], be[0]} : be;
   assign accept      = (state == IDLE) && req;
   assign is_io       = (addr == IO_ADDR);
   assign last_access = (state == ACCESS) && (wait_cnt == WS_CNT);

   assign s_we = accept ? we     : we_q;
   assign s_be = accept ? be_eff : be_q;
   assign s_io = accept ? is_io  : io_q;

   assign Data = data_oe ? wdata_q : 'z;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (req) state_nxt = is_io ? DONE : SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (wait_cnt == WS_CNT) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ce_n  = 1'b1;
      ub_n  = 1'b1;
      lb_n  = 1'b1;
      oe_n  = 1'b1;
      we_n  = 1'b1;
      drv_n = 1'b0;
      unique case (state_nxt)
         IDLE: ;
         SETUP: begin
            ce_n         = 1'b0;
            {ub_n, lb_n} = s_we ? ~s_be : 2'b00;
         end
         ACCESS: begin
            ce_n         = 1'b0;
            {ub_n, lb_n} = s_we ? ~s_be : 2'b00;
            oe_n         = s_we;
            we_n         = ~s_we;
            drv_n        = s_we;
         end
         DONE: begin
            // IO accesses never touch the SRAM, so CE stays high for them.
            ce_n         = s_io;
            {ub_n, lb_n} = s_io ? 2'b11 : (s_we ? ~s_be : 2'b00);
            drv_n        = s_we & ~s_io;
         end
      endcase
   end

   always_comb begin
      wext = '0;
      wext[DATA_W-1:0] = wdata;
      hex_mask = '0;
      for (int i = 0; i < HEX_W; i++) begin
         if (i < DATA_W) hex_mask[i] = (i >= 8) ? be_eff[1] : be_eff[0];
         else            hex_mask[i] = |be_eff;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
         we_q     <= 1'b0;
         io_q     <= 1'b0;
         be_q     <= 2'b00;
         wdata_q  <= '0;
         sw_meta  <= '0;
         sw_sync  <= '0;
         rdata    <= '0;
         hex      <= '0;
      end else begin
         state   <= state_nxt;
         sw_meta <= switches;
         sw_sync <= sw_meta;
         if (state_nxt == ACCESS && state != ACCESS) wait_cnt <= '0;
         else if (state == ACCESS)                    wait_cnt <= wait_cnt + 4'd1;
         if (accept) begin
            we_q    <= we;
            io_q    <= is_io;
            be_q    <= be_eff;
            wdata_q <= wdata;
         end
         if (last_access && !we_q)        rdata <= Data;
         if (accept && is_io && !we)      rdata <= sw_sync;
         if (accept && is_io && we)       hex   <= (hex & ~hex_mask) | (wext[HEX_W-1:0] & hex_mask);
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         CE      <= 1'b1;
         UB      <= 1'b1;
         LB      <= 1'b1;
         OE      <= 1'b1;
         WE      <= 1'b1;
         data_oe <= 1'b0;
         ack     <= 1'b0;
         busy    <= 1'b0;
         ADDR    <= '0;
      end else begin
         CE      <= ce_n;
         UB      <= ub_n;
         LB      <= lb_n;
         OE      <= oe_n;
         WE      <= we_n;
         data_oe <= drv_n;
         ack     <= (state_nxt == DONE);
         busy    <= (state_nxt != IDLE);
         if (accept && !is_io) ADDR <= addr;
      end
   end

endmodule

// File: doc/mem_io_bridge.md
MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 Parameter DATA_W, default 16, data bus width; SHALL be a multiple of 8 with value 8 or 16.
REQ-002 Parameter ADDR_W, default 20, SRAM word-address width.
REQ-003 Parameter WAIT_STATES, default 1, extra SRAM strobe cycles, range 0..15.
REQ-004 Parameter HEX_DIGITS, default 4, number of 4-bit hex display digits, range 1..8.
REQ-005 Parameter IO_ADDR, default all-ones of ADDR_W, the memory-mapped switch/hex address.
REQ-006 Port Clk  in  1  sole clock; all state changes on rising edge.
REQ-007 Port Reset  in  1  asynchronous, active-high reset.
REQ-008 Port req  in  1  CPU access request, sampled only in IDLE.
REQ-009 Port we  in  1  1 = write, 0 = read; sampled with req.
REQ-010 Port be  in  2  byte enables {upper, lower}; 2'b11 = full word; be[1] ignored when DATA_W=8.
REQ-011 Port addr  in  ADDR_W  CPU word address.
REQ-012 Port wdata  in  DATA_W  CPU write data.
REQ-013 Port rdata  out  DATA_W  read result; valid while ack=1 and held until the next read completes.
REQ-014 Port ack  out  1  one-cycle completion pulse.
REQ-015 Port busy  out  1  high from request acceptance through the ack cycle.
REQ-016 Port switches  in  DATA_W  asynchronous board switches.
REQ-017 Port hex  out  4*HEX_DIGITS  display register, digit 0 in bits [3:0].
REQ-018 Ports CE, UB, LB, OE, WE  out  1 each  SRAM strobes, active-low.
REQ-019 Port ADDR  out  ADDR_W  SRAM address.
REQ-020 Port Data  inout  DATA_W  SRAM data bus; tri-stated unless this block drives it for a write.

Function
REQ-021 The FSM SHALL have states IDLE, SETUP, ACCESS, DONE.
REQ-022 In IDLE with req=1 the block SHALL latch we, be, addr and wdata, and assert busy from the next cycle.
REQ-023 An accepted request with addr != IO_ADDR SHALL go to SETUP; one with addr == IO_ADDR SHALL go directly to DONE.
REQ-024 Strobes in SETUP: CE=0, ADDR=latched addr, OE=1, WE=1; UB/LB = ~be when latched we=1, else 0; the next state SHALL be ACCESS.
REQ-025 ACCESS SHALL last exactly WAIT_STATES+1 cycles, counted by a wait counter that is cleared on entry.
REQ-026 During an ACCESS read: OE=0 and WE=1; rdata SHALL capture Data on the last ACCESS cycle.
REQ-027 During an ACCESS write: OE=1, WE=0, and Data driven with the latched wdata.
REQ-028 In DONE: WE=1 and OE=1; Data stays driven for one hold cycle after a write; CE=0; ack=1.
REQ-029 DONE SHALL always return to IDLE next cycle; in IDLE, CE=OE=WE=UB=LB=1 and Data is tri-stated.
REQ-030 SRAM latency: ack SHALL assert WAIT_STATES+3 cycles after the cycle in which req is sampled.
REQ-031 IO latency: ack SHALL assert 1 cycle after the cycle in which req is sampled.
REQ-032 switches SHALL pass through a two-flop synchroniser; an IO read returns the synchronised value in rdata.
REQ-033 An IO write SHALL update hex with the low 4*HEX_DIGITS bits of wdata, zero-extended if wider than DATA_W, gated per byte by be.
REQ-034 req asserted while busy=1 SHALL be ignored; no queueing.
REQ-035 A new req in the cycle after DONE SHALL be accepted, giving back-to-back accesses with one IDLE cycle between them.
REQ-036 ADDR SHALL hold the latched address from SETUP through DONE; no strobe shall glitch within a state.

Reset
REQ-037 On Reset=1, immediately and asynchronously: state=IDLE; CE=UB=LB=OE=WE=1; Data tri-stated; ack=0; busy=0; rdata=0; hex=0; synchroniser=0; wait counter=0; ADDR=0.
REQ-038 Reset asserted mid-access SHALL abort it with no ack; the first req after release SHALL be serviced normally.

Verification
REQ-039 SRAM write with WAIT_STATES=1, addr=0x00123, wdata=0xBEEF, be=11 -> WE low for exactly 2 cycles, Data=0xBEEF from ACCESS through DONE, ack on cycle 4, then tri-state.
REQ-040 SRAM read of 0x00123 after that write, against the SRAM model -> OE low 2 cycles, rdata=0xBEEF with ack on cycle 4, UB=LB=0.
REQ-041 IO write 0x1234 to IO_ADDR, then switches=0xA5C3 held 3 cycles and IO read -> hex=0x1234, rdata=0xA5C3, each ack 1 cycle after req, CE never low.
REQ-042 Byte write with be=01, wdata=0xFFAA, to a word holding 0xBEEF -> UB=1, LB=0 during the strobe; a read then returns 0xBEAA.
REQ-043 Reset pulsed during the second ACCESS cycle of a write -> all strobes high in the same cycle, no ack, Data high-Z, hex=0; the next read completes normally.
REQ-044 req held high continuously for 20 cycles with WAIT_STATES=0 -> exactly one ack per 4 cycles, busy low only in the IDLE cycles.
